// File: rtl/pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_pkg
// Shared definitions for the pipe_stage_buf pipeline register stage:
//   - default operand/address/opcode widths and operand channel count
//   - FSM state encoding
//   - beat record layout for the default widths
//   - helper that computes the flat width of one beat for any parameter set
// -----------------------------------------------------------------------------
package pipe_stage_pkg;

  localparam int DEF_DATA_W  = 6;
  localparam int DEF_ADR_W   = 6;
  localparam int DEF_OP_W    = 2;
  localparam int DEF_NUM_OPS = 2;

  // Flow-control state of the stage. ST_TWO is only reachable when the skid
  // entry is built in; ST_HALT_DRAIN is sticky until rst or flush.
  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_ONE        = 2'd1,
    ST_TWO        = 2'd2,
    ST_HALT_DRAIN = 2'd3
  } state_e;

  // One beat at the default widths. Field order matches the flat packing
  // used inside the stage: {halted, write_adr, alu_inst, data}.
  typedef struct packed {
    logic                                halted;
    logic [DEF_ADR_W-1:0]                write_adr;
    logic [DEF_OP_W-1:0]                 alu_inst;
    logic [DEF_NUM_OPS*DEF_DATA_W-1:0]   data;
  } beat_t;

  // Flat width of one beat for an arbitrary parameterisation.
  function automatic int beat_width(input int data_w, input int adr_w,
                                    input int op_w, input int num_ops);
    return 1 + adr_w + op_w + (data_w * num_ops);
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// -----------------------------------------------------------------------------
// pipe_stage_slot
// One beat register with synchronous load and clear. Clear wins over load so a
// flush can never leave a half-updated beat behind.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, forces q to zero
//   load   - capture d on the next edge
//   clear  - zero the slot on the next edge (priority over load)
//   d      - beat to capture
//   q      - held beat
// -----------------------------------------------------------------------------
module pipe_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the stage samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Valid/ready pipeline register stage with optional skid entry, global freeze,
// flush and a sticky halt marker.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   - two entries (head + skid), in_ready is a registered signal
//               gated only by freeze/flush, so there is no combinational path
//               from out_ready to in_ready.
//   undefined - single head entry, in_ready follows out_ready combinationally
//               so a full stage can still accept in the cycle it drains.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   in_valid / in_ready           - upstream handshake
//   in_halted, in_write_adr,
//   in_alu_inst, in_data          - upstream beat fields (in_data packs
//                                   NUM_OPS channels, channel k at k*DATA_W)
//   flush                         - drop every held beat, clear halt
//   freeze                        - global stall, nothing moves
//   out_valid / out_ready         - downstream handshake for the head beat
//   out_halted, out_write_adr,
//   out_alu_inst, out_data        - registered head-beat fields
//   occupancy                     - number of held beats (0..2)
//   halt_latched                  - a halt beat has been accepted
// -----------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_halted,
  input  logic [ADR_W-1:0]          in_write_adr,
  input  logic [OP_W-1:0]           in_alu_inst,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  input  logic                      flush,
  input  logic                      freeze,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_halted,
  output logic [ADR_W-1:0]          out_write_adr,
  output logic [OP_W-1:0]           out_alu_inst,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic [1:0]                occupancy,
  output logic                      halt_latched
);

  localparam int BEAT_W = beat_width(DATA_W, ADR_W, OP_W, NUM_OPS);

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] CAPACITY = 2'd2;
`else
  localparam logic [1:0] CAPACITY = 2'd1;
`endif

  state_e            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept, transfer;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] head_d, head_q;
  logic              head_load;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign in_beat   = {in_halted, in_write_adr, in_alu_inst, in_data};
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready && !freeze;

  assign out_valid    = (occ_q != 2'd0);
  assign occupancy    = occ_q;
  assign halt_latched = (state_q == ST_HALT_DRAIN);

  assign {out_halted, out_write_adr, out_alu_inst, out_data} = head_q;

  // ---------------------------------------------------------------------------
  // Occupancy and FSM next state. in_ready already folds in freeze and flush,
  // so under freeze both accept and transfer are low and nothing changes.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default on entry so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else if (accept && !transfer) begin
      occ_d = occ_q + 2'd1;
    end else if (!accept && transfer) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (halt_latched || (accept && in_halted)) begin
      // Halt is sticky; held beats keep draining while occupancy counts down.
      state_d = ST_HALT_DRAIN;
    end else begin
      case (occ_d)
        2'd0:    state_d = ST_EMPTY;
        2'd1:    state_d = ST_ONE;
        default: state_d = ST_TWO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // ---------------------------------------------------------------------------
  // Two-entry datapath: head feeds the outputs, skid catches the beat that
  // arrives while the head is stalled. On a transfer with both full the skid
  // moves into the head in the same edge, so there is no bubble.
  // ---------------------------------------------------------------------------
  logic [BEAT_W-1:0] skid_q;
  logic              skid_load;
  logic              ready_q;

  assign head_load = (accept && ((occ_q == 2'd0) || transfer)) ||
                     (transfer && (occ_q == 2'd2));
  assign head_d    = (occ_q == 2'd2) ? skid_q : in_beat;
  assign skid_load = accept && (occ_q == 2'd1) && !transfer;

  // Space/halt part of in_ready is computed from next-state values and
  // registered; freeze and flush are global controls applied on top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d != ST_HALT_DRAIN) && (occ_d < CAPACITY);
    end
  end

  assign in_ready = ready_q && !freeze && !flush;

  pipe_stage_slot #(.W(BEAT_W)) u_skid_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (flush),
    .d     (in_beat),
    .q     (skid_q)
  );
`else
  // ---------------------------------------------------------------------------
  // Single-entry datapath: an accept can only happen into an empty head or in
  // the cycle the head leaves, so the head always loads straight from input.
  // init_q keeps in_ready low while rst is held and raises it on the first
  // edge after release.
  // ---------------------------------------------------------------------------
  logic init_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  assign in_ready  = init_q && !freeze && !halt_latched && !flush &&
                     ((occ_q == 2'd0) || transfer);
  assign head_load = accept;
  assign head_d    = in_beat;
`endif

  pipe_stage_slot #(.W(BEAT_W)) u_head_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (flush),
    .d     (head_d),
    .q     (head_q)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Self-checking bench for pipe_stage_buf at default widths. Works with and
// without PIPE_STAGE_SKID_EN; CAP tracks the expected capacity.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;
  import pipe_stage_pkg::*;

  localparam int DW = DEF_NUM_OPS * DEF_DATA_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_halted;
  logic [DEF_ADR_W-1:0] in_write_adr;
  logic [DEF_OP_W-1:0]  in_alu_inst;
  logic [DW-1:0]        in_data;
  logic                 flush;
  logic                 freeze;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_halted;
  logic [DEF_ADR_W-1:0] out_write_adr;
  logic [DEF_OP_W-1:0]  out_alu_inst;
  logic [DW-1:0]        out_data;
  logic [1:0]           occupancy;
  logic                 halt_latched;

  int    checks;
  int    errors;
  bit    last_acc;
  beat_t sb_q[$];

  pipe_stage_buf #(
    .DATA_W (DEF_DATA_W),
    .ADR_W  (DEF_ADR_W),
    .OP_W   (DEF_OP_W),
    .NUM_OPS(DEF_NUM_OPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_halted    (in_halted),
    .in_write_adr (in_write_adr),
    .in_alu_inst  (in_alu_inst),
    .in_data      (in_data),
    .flush        (flush),
    .freeze       (freeze),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_halted   (out_halted),
    .out_write_adr(out_write_adr),
    .out_alu_inst (out_alu_inst),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .halt_latched (halt_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic beat_t mk(input int n);
    beat_t b;
    int    t;
    t           = n * 37 + 5;
    b.halted    = 1'b0;
    b.write_adr = n[DEF_ADR_W-1:0];
    b.alu_inst  = n[DEF_OP_W-1:0];
    b.data      = t[DW-1:0];
    return b;
  endfunction

  task automatic drive(input beat_t b);
    in_valid     = 1'b1;
    in_halted    = b.halted;
    in_write_adr = b.write_adr;
    in_alu_inst  = b.alu_inst;
    in_data      = b.data;
  endtask

  // Advance one clock. Handshakes are sampled just before the edge: accepted
  // beats go into the scoreboard, departing beats are popped and compared.
  task automatic tick();
    beat_t exp_b;
    beat_t got_b;
    #1;
    last_acc = 1'b0;
    if (!rst) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready && !freeze) begin
          checks++;
          got_b = {out_halted, out_write_adr, out_alu_inst, out_data};
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: beat %h left with nothing expected", got_b);
          end else begin
            exp_b = sb_q.pop_front();
            if (got_b !== exp_b) begin
              errors++;
              $display("FAIL sb_beat: got %h expected %h", got_b, exp_b);
            end
          end
        end
        if (in_valid && in_ready) begin
          last_acc = 1'b1;
          sb_q.push_back({in_halted, in_write_adr, in_alu_inst, in_data});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_halted = 1'b0; in_write_adr = '0;
    in_alu_inst = '0; in_data = '0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    #3;
    checks++;
    if ({out_valid, occupancy, halt_latched, in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {out_valid, occupancy, halt_latched, in_ready});
    end
    checks++;
    if ({out_halted, out_write_adr, out_alu_inst, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0", {out_halted, out_write_adr, out_alu_inst, out_data});
    end
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    beat_t b;
    b = '0;
    b.write_adr = 6'h05;
    b.alu_inst  = 2'b01;
    b.data      = {6'h0A, 6'h14};
    drive(b);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_write_adr, out_alu_inst, out_data, occupancy} !==
        {1'b1, 6'h05, 2'b01, 12'h294, 2'd1}) begin
      errors++;
      $display("FAIL single_out: got v=%b adr=%h op=%b d=%h occ=%0d expected v=1 adr=05 op=01 d=294 occ=1",
               out_valid, out_write_adr, out_alu_inst, out_data, occupancy);
    end
    tick();
    checks++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++;
      $display("FAIL single_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    beat_t b;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(mk(10 + i));
      #1;
      checks++;
      if (in_ready !== (i <= CAP)) begin
        errors++;
        $display("FAIL fill_ready_%0d: got %b expected %b", i, in_ready, (i <= CAP));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'(CAP)) begin
      errors++;
      $display("FAIL fill_occ: got %0d expected %0d", occupancy, CAP);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= CAP; i++) begin
      b = mk(10 + i);
      checks++;
      if ({out_valid, out_write_adr} !== {1'b1, b.write_adr}) begin
        errors++;
        $display("FAIL fill_order_%0d: got v=%b adr=%h expected v=1 adr=%h", i, out_valid, out_write_adr, b.write_adr);
      end
      tick();
    end
    checks++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++;
      $display("FAIL fill_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_freeze();
    beat_t b;
    out_ready = 1'b0;
    for (int i = 1; i <= CAP; i++) begin
      drive(mk(20 + i));
      tick();
    end
    b = mk(21);
    drive(mk(99));
    freeze = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL freeze_ready_%0d: got %b expected 0", c, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, occupancy, out_write_adr, out_data} !== {1'b1, 2'(CAP), b.write_adr, b.data}) begin
        errors++;
        $display("FAIL freeze_hold_%0d: got v=%b occ=%0d adr=%h d=%h expected v=1 occ=%0d adr=%h d=%h",
                 c, out_valid, occupancy, out_write_adr, out_data, CAP, b.write_adr, b.data);
      end
    end
    freeze = 1'b0;
    in_valid = 1'b0;
    for (int k = 1; k <= CAP; k++) begin
      tick();
      checks++;
      if (occupancy !== 2'(CAP - k)) begin
        errors++;
        $display("FAIL freeze_drain_%0d: got occ=%0d expected %0d", k, occupancy, CAP - k);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_halt();
    beat_t h;
    out_ready = 1'b0;
    h = mk(30);
    h.halted = 1'b1;
    drive(h);
    tick();
    drive(mk(31));
    checks++;
    if ({halt_latched, occupancy, out_halted} !== 4'b1011) begin
      errors++;
      $display("FAIL halt_set: got halt=%b occ=%0d oh=%b expected halt=1 occ=1 oh=1", halt_latched, occupancy, out_halted);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL halt_ready_%0d: got %b expected 0", c, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, occupancy, halt_latched, in_ready} !== 5'b00010) begin
      errors++;
      $display("FAIL halt_drain: got v=%b occ=%0d halt=%b rdy=%b expected v=0 occ=0 halt=1 rdy=0",
               out_valid, occupancy, halt_latched, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({halt_latched, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL halt_flush: got halt=%b rdy=%b expected halt=0 rdy=1", halt_latched, in_ready);
    end
  endtask

  task automatic test_flush_accept();
    out_ready = 1'b0;
    drive(mk(40));
    tick();
    checks++;
    if (occupancy !== 2'd1) begin
      errors++;
      $display("FAIL flush_pre_occ: got %0d expected 1", occupancy);
    end
    drive(mk(41));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++;
      $display("FAIL flush_clear: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_beat_%0d: got v=%b expected 0", c, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= CAP; i++) begin
      drive(mk(50 + i));
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'(CAP)) begin
      errors++;
      $display("FAIL areset_pre_occ: got %0d expected %0d", occupancy, CAP);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, occupancy, halt_latched, in_ready, out_halted, out_write_adr, out_alu_inst, out_data} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got v=%b occ=%0d halt=%b rdy=%b fields=%h expected all 0",
               out_valid, occupancy, halt_latched, in_ready,
               {out_halted, out_write_adr, out_alu_inst, out_data});
    end
    sb_q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, occupancy, out_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL areset_release: got rdy=%b occ=%0d v=%b expected rdy=1 occ=0 v=0", in_ready, occupancy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (n < 8 && cyc < 40) begin
      drive(mk(60 + n));
      tick();
      cyc++;
      if (last_acc) n++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d cycles for 8 beats expected 8", cyc);
    end
    n = 0;
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 3) != 0) drive(mk(100 + n));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      freeze    = ($urandom_range(0, 9) == 0);
      tick();
      if (last_acc) n++;
    end
    in_valid = 1'b0;
    freeze = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if ({out_valid, 32'(sb_q.size())} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL b2b_final_drain: got v=%b pending=%0d expected v=0 pending=0", out_valid, sb_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_acc = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_freeze();
    test_halt();
    test_flush_accept();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
